// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit
// ----------------------------------------------------------------------------
// Fetch stage of the RV32I core. Holds the PC and issues one word-aligned read
// at a time to instruction memory. The returned word is registered and handed
// to decode together with its PC. Execute may redirect the PC at any time.
//
// Ports
//   clk            core clock, rising edge
//   rst_n          asynchronous active-low reset
//   imem_req       read request (memory accepts every cycle it is high)
//   imem_addr      read address, word aligned
//   imem_rvalid    read data valid (one outstanding read)
//   imem_rdata     read data
//   redirect_valid load PC with redirect_pc this cycle
//   redirect_pc    redirect target
//   instr_valid    instr/instr_pc valid to decode
//   instr_ready    decode accepts (transfer = instr_valid & instr_ready)
//   instr          fetched instruction (NOP_INSTR when not valid)
//   instr_pc       address of instr
//   fetch_err      misaligned redirect flag
//
// Configuration
//   MISALIGN_TRAP_EN  when defined, a misaligned redirect parks the unit in
//                     an ERR state that presents a NOP with fetch_err=1 until
//                     the next redirect. When undefined, the two low bits of
//                     redirect_pc are forced to zero and fetch_err is tied 0.
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {FETCH, WAIT, HOLD, ERR} state_t;
`else
    typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        req_q;
    logic [31:0] redirTarget;

`ifdef MISALIGN_TRAP_EN
    logic        err_q, err_d;
    logic        misaligned;

    // A misaligned target is kept as-is so decode can see the faulting PC.
    assign redirTarget = redirect_pc;
    assign misaligned  = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    // Without the trap, low bits are simply dropped.
    assign redirTarget = redirect_pc & ~32'h0000_0003;
`endif

    // Next-state logic. kill marks the outstanding read as stale so that
    // its data is dropped when it finally returns.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef MISALIGN_TRAP_EN
        err_d      = err_q;
`endif

        case (state_q)
            FETCH: begin
                // The request goes out this cycle regardless of a redirect.
                state_d = WAIT;
                if (redirect_valid) begin
                    pc_d   = redirTarget;
                    kill_d = 1'b1;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirTarget;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = FETCH;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end

            HOLD: begin
                // A transfer coinciding with a redirect still completes, but
                // the PC follows the redirect instead of advancing.
                if (redirect_valid) begin
                    pc_d    = redirTarget;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end
            end

`ifdef MISALIGN_TRAP_EN
            ERR: begin
                // A read issued just before entering ERR may still return.
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                end
                if (redirect_valid) begin
                    pc_d    = redirTarget;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    // With a read still in flight, wait it out before fetching.
                    state_d = (kill_q && !imem_rvalid) ? WAIT : FETCH;
                end
            end
`endif

            default: begin
                state_d = FETCH;
            end
        endcase

`ifdef MISALIGN_TRAP_EN
        // Misaligned redirect overrides everything above. kill must reflect
        // whether a read is still outstanding after this edge.
        if (misaligned) begin
            pc_d       = redirect_pc;
            state_d    = ERR;
            valid_d    = 1'b1;
            err_d      = 1'b1;
            instr_d    = NOP_INSTR;
            instr_pc_d = redirect_pc;
            case (state_q)
                FETCH:   kill_d = 1'b1;
                WAIT:    kill_d = !imem_rvalid;
                HOLD:    kill_d = 1'b0;
                default: kill_d = kill_q && !imem_rvalid;
            endcase
        end
`endif
    end

    // State and registered outputs. imem_req is registered from the next
    // state so it is high exactly in FETCH cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            req_q      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            req_q      <= (state_d == FETCH);
`ifdef MISALIGN_TRAP_EN
            err_q      <= err_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
`ifdef MISALIGN_TRAP_EN
    assign fetch_err   = err_q;
`else
    assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for instr_fetch_unit (default build, trap disabled).
// A transaction-level model tracks the architectural PC, whether a read is
// in flight (and whether a redirect made it stale), and whether an
// instruction is being presented. Memory contents are a function of the
// address; stale reads return 0xDEADBEEF so any leak is visible.
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;

    instr_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] expPc;
    bit          expReq;
    bit          presenting;
    bit          outstanding;
    bit          outStale;
    logic [31:0] outAddr;
    int          outDelay;
    int          cycle = 0;
    int          lastTransfer = -1;
    bit          checkInterval = 1'b0;

    // Instruction memory contents
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h cycle=%0d",
                     tag, observed, expected, cycle);
        end
    endtask

    task automatic resetModel();
        expPc       = RESET_PC;
        expReq      = 1'b1;
        presenting  = 1'b0;
        outstanding = 1'b0;
        outStale    = 1'b0;
        outAddr     = 32'h0;
        outDelay    = 0;
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the
    // model, then move to #1 after the next rising edge.
    // mode: 0 random, 1 redirect while a read is in flight,
    //       2 redirect while presenting with ready=1, 3 hold ready low.
    task automatic applyStimulus(input int redirPct, input int readyPct,
                                 input int maxLat, input int mode,
                                 input logic [31:0] forceTarget,
                                 output bit fired);
        bit          rv;
        bit          spurious;
        bit          redir;
        bit          ready;
        bit          transfer;
        bit          nPres;
        bit          nReq;
        logic [31:0] target;
        logic [31:0] tgt;

        checkOutput("instr_valid", 32'(instr_valid), 32'(presenting));
        if (presenting) begin
            checkOutput("instr_pc", instr_pc, expPc);
            checkOutput("instr", instr, memWord(expPc));
        end else begin
            checkOutput("instr_nop", instr, NOP);
        end
        checkOutput("imem_req", 32'(imem_req), 32'(expReq));
        if (expReq) begin
            checkOutput("imem_addr", imem_addr, expPc);
        end
        checkOutput("fetch_err", 32'(fetch_err), 32'h0);

        fired = 1'b0;
        rv = outstanding && (outDelay == 1);
        spurious = presenting && !outstanding && ($urandom_range(0, 9) == 0);

        case (mode)
            1:       redir = outstanding;
            2:       redir = presenting;
            3:       redir = 1'b0;
            default: redir = ($urandom_range(0, 99) < redirPct);
        endcase
        if (mode == 1 || mode == 2) begin
            target = forceTarget;
            fired  = redir;
        end else if ($urandom_range(0, 3) == 0) begin
            target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        end else begin
            target = $urandom;
        end
        tgt = target & ~32'h3;

        if (mode == 2 && redir) begin
            ready = 1'b1;
        end else if (mode == 3) begin
            ready = 1'b0;
        end else begin
            ready = ($urandom_range(0, 99) < readyPct);
        end

        imem_rvalid    = rv || spurious;
        imem_rdata     = rv ? (outStale ? 32'hDEAD_BEEF : memWord(outAddr)) : $urandom;
        redirect_valid = redir;
        redirect_pc    = target;
        instr_ready    = ready;

        transfer = presenting && ready;
        nReq  = 1'b0;
        nPres = presenting;
        if (presenting && (redir || ready)) begin
            nPres = 1'b0;
            nReq  = 1'b1;
        end
        if (rv) begin
            if (!outStale && !redir) begin
                nPres = 1'b1;
            end else begin
                nReq = 1'b1;
            end
            outstanding = 1'b0;
        end else if (outstanding) begin
            outDelay--;
            if (redir) begin
                outStale = 1'b1;
            end
        end
        if (expReq) begin
            outstanding = 1'b1;
            outAddr     = expPc;
            outStale    = redir;
            outDelay    = $urandom_range(1, maxLat);
        end

        if (transfer) begin
            if (checkInterval && lastTransfer >= 0) begin
                checkOutput("issue_interval", cycle - lastTransfer, 32'd3);
            end
            lastTransfer = cycle;
        end

        if (redir) begin
            expPc = tgt;
        end else if (transfer) begin
            expPc = expPc + 32'd4;
        end
        presenting = nPres;
        expReq     = nReq;

        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        bit fired;
        bit seen;

        resetModel();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Straight-line fetch with single-cycle memory and ready decode
        checkInterval = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end
        checkInterval = 1'b0;

        // Stall decode for five cycles while an instruction is held
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (presenting) begin
                seen = 1'b1;
            end else begin
                applyStimulus(0, 0, 1, 3, 32'h0, fired);
            end
        end
        checkOutput("stall_reached_hold", 32'(seen), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 3, 32'h0, fired);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end

        // Redirect while a read is in flight, then coincident with transfer,
        // then a misaligned target, then a target that wraps past the top
        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            applyStimulus(0, 100, 1, 1, 32'h0000_0200, fired);
        end
        checkOutput("redirect_wait_fired", 32'(fired), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end

        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            applyStimulus(0, 0, 1, 2, 32'h0000_0300, fired);
        end
        checkOutput("redirect_hold_fired", 32'(fired), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end

        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            applyStimulus(0, 0, 2, 2, 32'h0000_0202, fired);
        end
        checkOutput("redirect_misaligned_fired", 32'(fired), 32'h1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end

        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            applyStimulus(0, 0, 1, 2, 32'hFFFF_FFFC, fired);
        end
        checkOutput("redirect_wrap_fired", 32'(fired), 32'h1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 100, 1, 0, 32'h0, fired);
        end

        // Random traffic: redirects, variable latency, decode back-pressure
        for (int i = 0; i < 400; i++) begin
            applyStimulus(10, 60, 3, 0, 32'h0, fired);
        end

        // Reset in the middle of operation
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        checkOutput("midreset_req", 32'(imem_req), 32'h1);
        checkOutput("midreset_addr", imem_addr, RESET_PC);
        checkOutput("midreset_valid", 32'(instr_valid), 32'h0);
        checkOutput("midreset_instr", instr, NOP);
        checkOutput("midreset_instr_pc", instr_pc, RESET_PC);
        checkOutput("midreset_err", 32'(fetch_err), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(10, 60, 3, 0, 32'h0, fired);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
